// File: rtl/trdb_pkg.sv
// trdb_pkg: shared state/packet types for the trace-session controller.
package trdb_pkg;
   localparam int unsigned RESYNC_W_DEF = 16;
   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      ARMED      = 3'd1,
      SEND_START = 3'd2,
      TRACING    = 3'd3,
      SEND_STOP  = 3'd4
   } trace_ctrl_state_e;
   typedef enum logic [1:0] {
      PKT_START  = 2'd0,
      PKT_RESYNC = 2'd1,
      PKT_STOP   = 2'd2
   } pkt_kind_e;
   // Kind reads as START whenever no request is outstanding, so idle outputs stay 0.
   function automatic pkt_kind_e kind_of(trace_ctrl_state_e s, logic rs_pend);
      return s == SEND_STOP ? PKT_STOP : (s == TRACING && rs_pend) ? PKT_RESYNC : PKT_START;
   endfunction
endpackage

// File: rtl/trdb_resync_cnt.sv
// trdb_resync_cnt: saturating retired-instruction counter with resync-due detection.
module trdb_resync_cnt #(
   parameter int unsigned W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         inc_i,
   input  logic         hold_i,
   input  logic [W-1:0] max_i,
   output logic         hit_o
);
   logic [W-1:0] r_cnt;
   logic [W:0]   w_next;
   logic         w_step;
   assign w_next = {1'b0, r_cnt} + (W+1)'(1);
   assign w_step = inc_i & ~hold_i;
   // Compare >= so a threshold lowered below the count fires on the next retire.
   assign hit_o  = w_step & (max_i != '0) & (w_next >= {1'b0, max_i});
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i)
         r_cnt <= '0;
      else if (hit_o)
         r_cnt <= max_i;
      else if (w_step && !w_next[W])
         r_cnt <= w_next[W-1:0];
   end
endmodule

// File: rtl/trdb_trace_ctrl.sv
// trdb_trace_ctrl: trace-session FSM; sequences START/RESYNC/STOP requests over req/ack.
module trdb_trace_ctrl
   import trdb_pkg::*;
#(
   parameter int unsigned RESYNC_W = RESYNC_W_DEF
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                trace_enable_i,
   input  logic                trace_req_deactivate_i,
   input  logic                trace_qualified_i,
   input  logic                iretire_i,
   input  logic [RESYNC_W-1:0] resync_max_i,
   output logic                trace_activated_o,
   output logic                trace_on_o,
   output logic                packet_req_o,
   output logic [1:0]          packet_kind_o,
   input  logic                packet_ack_i,
   output logic                enable_clr_o
);
   trace_ctrl_state_e r_state, w_state_nxt;
   logic r_exit_pend, r_deact_pend, r_rs_pend, r_clr;
   logic w_exit_nxt, w_deact_nxt, w_rs_nxt, w_clr_nxt;
   logic w_exit, w_ack, w_deact_acc, w_inc, w_hit, w_cnt_clr;

   assign w_exit      = trace_req_deactivate_i | ~trace_enable_i | (iretire_i & ~trace_qualified_i);
   assign w_ack       = packet_ack_i & packet_req_o;
   assign w_deact_acc = r_deact_pend | trace_req_deactivate_i;
   // An exit in the same cycle wins over counting, which drops a coincident RESYNC.
   assign w_inc       = (r_state == TRACING) & ~r_rs_pend & ~w_exit & iretire_i;

   trdb_resync_cnt #(.W(RESYNC_W)) u_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (w_cnt_clr),
      .inc_i  (w_inc),
      .hold_i (r_rs_pend),
      .max_i  (resync_max_i),
      .hit_o  (w_hit)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= IDLE;
         r_exit_pend  <= 1'b0;
         r_deact_pend <= 1'b0;
         r_rs_pend    <= 1'b0;
         r_clr        <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_exit_pend  <= w_exit_nxt;
         r_deact_pend <= w_deact_nxt;
         r_rs_pend    <= w_rs_nxt;
         r_clr        <= w_clr_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_exit_nxt  = r_exit_pend;
      w_deact_nxt = r_deact_pend;
      w_rs_nxt    = r_rs_pend;
      w_clr_nxt   = 1'b0;
      w_cnt_clr   = 1'b0;
      case (r_state)
         IDLE: begin
            w_exit_nxt  = 1'b0;
            w_deact_nxt = 1'b0;
            w_rs_nxt    = 1'b0;
            if (trace_enable_i) w_state_nxt = ARMED;
         end
         ARMED: begin
            if (trace_req_deactivate_i) begin
               w_state_nxt = IDLE;
               w_clr_nxt   = 1'b1;
            end else if (!trace_enable_i)
               w_state_nxt = IDLE;
            else if (iretire_i && trace_qualified_i)
               w_state_nxt = SEND_START;
         end
         SEND_START: begin
            if (w_exit) begin
               w_exit_nxt  = 1'b1;
               w_deact_nxt = w_deact_acc;
            end
            if (w_ack) begin
               w_cnt_clr   = 1'b1;
               w_state_nxt = (r_exit_pend || w_exit) ? SEND_STOP : TRACING;
            end
         end
         TRACING: begin
            if (r_rs_pend) begin
               if (w_exit) begin
                  w_exit_nxt  = 1'b1;
                  w_deact_nxt = w_deact_acc;
               end
               if (w_ack) begin
                  w_cnt_clr = 1'b1;
                  w_rs_nxt  = 1'b0;
                  if (r_exit_pend || w_exit) w_state_nxt = SEND_STOP;
               end
            end else if (w_exit) begin
               w_state_nxt = SEND_STOP;
               w_deact_nxt = trace_req_deactivate_i;
            end else if (w_hit)
               w_rs_nxt = 1'b1;
         end
         SEND_STOP: begin
            w_deact_nxt = w_deact_acc;
            if (w_ack) begin
               w_state_nxt = (w_deact_acc || !trace_enable_i) ? IDLE : ARMED;
               w_clr_nxt   = w_deact_acc;
               w_exit_nxt  = 1'b0;
               w_deact_nxt = 1'b0;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      trace_activated_o = r_state != IDLE;
      trace_on_o        = r_state == TRACING;
      packet_req_o      = (r_state == SEND_START) | (r_state == SEND_STOP) | ((r_state == TRACING) & r_rs_pend);
      packet_kind_o     = kind_of(r_state, r_rs_pend);
      enable_clr_o      = r_clr;
   end
endmodule
